// File: rtl/passcode_lock_checker.sv
// ============================================================================
// Module   : passcode_lock_checker
// Brief    : Compares entered passcode digits against a stored combination and
//            drives the unlock window, failure counting and timed lockout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module passcode_lock_checker #(
    parameter int                     SEQ_LEN        = 4,
    parameter logic [SEQ_LEN*5-1:0]   CODE_SEQ       = {5'd28, 5'd3, 5'd19, 5'd7},
    parameter int                     MAX_FAILS      = 3,
    parameter int                     UNLOCK_CYCLES  = 500,
    parameter int                     LOCKOUT_CYCLES = 1000,
    parameter int                     ENTRY_TIMEOUT  = 200
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             code_valid,
    input  logic [4:0]                       code,
    input  logic                             code_invalid,
    input  logic                             clear,
    output logic                             ready,
    output logic                             unlocked,
    output logic                             locked_out,
    output logic [$clog2(SEQ_LEN+1)-1:0]     digit_count,
    output logic [$clog2(MAX_FAILS+1)-1:0]   fail_count,
    output logic                             pass_pulse,
    output logic                             fail_pulse,
    output logic                             timeout_pulse
);

    localparam int DCW  = $clog2(SEQ_LEN + 1);
    localparam int FCW  = $clog2(MAX_FAILS + 1);
    localparam int TMAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES)
                        ? ((UNLOCK_CYCLES > ENTRY_TIMEOUT) ? UNLOCK_CYCLES : ENTRY_TIMEOUT)
                        : ((LOCKOUT_CYCLES > ENTRY_TIMEOUT) ? LOCKOUT_CYCLES : ENTRY_TIMEOUT);
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [1:0] {
        ST_ENTRY    = 2'd0,
        ST_UNLOCKED = 2'd1,
        ST_LOCKOUT  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [DCW-1:0]   digit_count_q, digit_count_d;
    logic [FCW-1:0]   fail_count_q, fail_count_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             mismatch_q, mismatch_d;
    logic             unlocked_q, unlocked_d;
    logic             locked_out_q, locked_out_d;
    logic             pass_pulse_q, pass_pulse_d;
    logic             fail_pulse_q, fail_pulse_d;
    logic             timeout_pulse_q, timeout_pulse_d;

    logic             accept;
    logic [4:0]       exp_digit;
    logic             attempt_bad;

    assign ready     = (state_q == ST_ENTRY) & ~rst;
    assign accept    = code_valid & ready & ~clear;
    assign exp_digit = CODE_SEQ[int'(digit_count_q) * 5 +: 5];
    // Sticky across the attempt so per-digit correctness never leaks out.
    assign attempt_bad = mismatch_q | code_invalid | (code != exp_digit);

    always_comb begin
        state_d         = state_q;
        digit_count_d   = digit_count_q;
        fail_count_d    = fail_count_q;
        timer_d         = timer_q;
        mismatch_d      = mismatch_q;
        unlocked_d      = unlocked_q;
        locked_out_d    = locked_out_q;
        pass_pulse_d    = 1'b0;
        fail_pulse_d    = 1'b0;
        timeout_pulse_d = 1'b0;

        case (state_q)
            ST_ENTRY: begin
                if (clear) begin
                    digit_count_d = '0;
                    mismatch_d    = 1'b0;
                    timer_d       = '0;
                end else if (accept) begin
                    timer_d = '0;
                    if (digit_count_q == DCW'(SEQ_LEN - 1)) begin
                        digit_count_d = '0;
                        mismatch_d    = 1'b0;
                        if (!attempt_bad) begin
                            state_d      = ST_UNLOCKED;
                            unlocked_d   = 1'b1;
                            pass_pulse_d = 1'b1;
                            fail_count_d = '0;
                        end else if (int'(fail_count_q) + 1 >= MAX_FAILS) begin
                            state_d      = ST_LOCKOUT;
                            locked_out_d = 1'b1;
                            fail_pulse_d = 1'b1;
                            fail_count_d = FCW'(MAX_FAILS);
                        end else begin
                            fail_pulse_d = 1'b1;
                            fail_count_d = fail_count_q + FCW'(1);
                        end
                    end else begin
                        digit_count_d = digit_count_q + DCW'(1);
                        mismatch_d    = attempt_bad;
                    end
                end else if (digit_count_q != '0) begin
                    if (timer_q == TW'(ENTRY_TIMEOUT - 1)) begin
                        digit_count_d   = '0;
                        mismatch_d      = 1'b0;
                        timer_d         = '0;
                        timeout_pulse_d = 1'b1;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
            end

            ST_UNLOCKED: begin
                if (clear || timer_q == TW'(UNLOCK_CYCLES - 1)) begin
                    state_d    = ST_ENTRY;
                    unlocked_d = 1'b0;
                    timer_d    = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

            ST_LOCKOUT: begin
                if (timer_q == TW'(LOCKOUT_CYCLES - 1)) begin
                    state_d      = ST_ENTRY;
                    locked_out_d = 1'b0;
                    fail_count_d = '0;
                    timer_d      = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

            default: begin
                state_d = ST_ENTRY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_ENTRY;
            digit_count_q   <= '0;
            fail_count_q    <= '0;
            timer_q         <= '0;
            mismatch_q      <= 1'b0;
            unlocked_q      <= 1'b0;
            locked_out_q    <= 1'b0;
            pass_pulse_q    <= 1'b0;
            fail_pulse_q    <= 1'b0;
            timeout_pulse_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            digit_count_q   <= digit_count_d;
            fail_count_q    <= fail_count_d;
            timer_q         <= timer_d;
            mismatch_q      <= mismatch_d;
            unlocked_q      <= unlocked_d;
            locked_out_q    <= locked_out_d;
            pass_pulse_q    <= pass_pulse_d;
            fail_pulse_q    <= fail_pulse_d;
            timeout_pulse_q <= timeout_pulse_d;
        end
    end

    assign unlocked      = unlocked_q;
    assign locked_out    = locked_out_q;
    assign digit_count   = digit_count_q;
    assign fail_count    = fail_count_q;
    assign pass_pulse    = pass_pulse_q;
    assign fail_pulse    = fail_pulse_q;
    assign timeout_pulse = timeout_pulse_q;

endmodule

`default_nettype wire

// File: doc/passcode_lock_checker.md
Name: passcode_lock_checker

Overview:
- Consumes the 5-bit passcode digits produced by the passcode converter and decides whether an entered sequence of SEQ_LEN digits matches a stored combination.
- Drives the lock: unlock window on match, failure counting on mismatch, and timed lockout after MAX_FAILS consecutive failures.
- Sits downstream of the converter, between the keypad/input path and the actuator/status logic.

Parameters:
- SEQ_LEN, 4, digits per entry attempt (2..8).
- CODE_SEQ, {5'd28,5'd3,5'd19,5'd7}, packed combination, SEQ_LEN*5 bits; digit k in bits [5k+4:5k], digit 0 entered first (default entry order 7,19,3,28).
- MAX_FAILS, 3, consecutive failed attempts that trigger lockout (>=1).
- UNLOCK_CYCLES, 500, cycles the unlocked output stays high.
- LOCKOUT_CYCLES, 1000, cycles of lockout.
- ENTRY_TIMEOUT, 200, idle cycles after a partial entry before it is discarded.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- code_valid  in  1  one-cycle strobe: code/code_invalid are valid
- code  in  5  digit from converter
- code_invalid  in  1  converter flagged out-of-range input; digit counts as wrong
- clear  in  1  abort entry / relock
- ready  out  1  digits accepted this cycle
- unlocked  out  1  unlock window active
- locked_out  out  1  lockout active
- digit_count  out  $clog2(SEQ_LEN+1)  digits accepted in the current attempt
- fail_count  out  $clog2(MAX_FAILS+1)  consecutive failures
- pass_pulse  out  1  one cycle, attempt matched
- fail_pulse  out  1  one cycle, attempt mismatched
- timeout_pulse  out  1  one cycle, partial entry discarded

Behaviour:
- States: ENTRY, UNLOCKED, LOCKOUT. All outputs are registered except ready, which equals (state==ENTRY) & ~rst.
- Reset (synchronous, while rst=1): state=ENTRY; digit_count, fail_count, mismatch flag, and timers = 0; unlocked, locked_out, and all pulses = 0. Reset mid-attempt, mid-unlock, or mid-lockout discards everything.
- ENTRY, digit accepted when code_valid & ready & ~clear: mismatch |= code_invalid | (code != CODE_SEQ digit[digit_count]); digit_count++; idle timer cleared.
- Final digit (digit_count==SEQ_LEN-1 when accepted): evaluated including the current digit, with the result registered at the same edge. Outputs change the cycle after the final strobe:
  - match: state->UNLOCKED, unlocked=1, pass_pulse=1, fail_count=0.
  - mismatch with fail_count+1<MAX_FAILS: fail_count++, fail_pulse=1, stay in ENTRY.
  - mismatch with fail_count+1==MAX_FAILS: fail_pulse=1, fail_count=MAX_FAILS, state->LOCKOUT, locked_out=1.
  - In all three cases digit_count and mismatch clear to 0.
- Per-digit correctness is never exposed. Failure is reported only after SEQ_LEN digits.
- Timeout: in ENTRY with digit_count>0, the idle timer counts cycles without an accepted digit. When it reaches ENTRY_TIMEOUT: digit_count=0, mismatch=0, timeout_pulse=1, fail_count unchanged.
- clear:
  - ENTRY: discards the partial attempt; digit_count=0, no pulses.
  - UNLOCKED: immediate relock; next cycle unlocked=0, state=ENTRY.
  - LOCKOUT: ignored.
  - clear with code_valid in the same cycle: clear wins and the digit is dropped.
- UNLOCKED: ready=0 and code_valid is ignored. After UNLOCK_CYCLES cycles with unlocked=1, unlocked falls and state->ENTRY.
- LOCKOUT: ready=0 and all inputs except rst are ignored. After LOCKOUT_CYCLES cycles, locked_out falls, state->ENTRY, fail_count=0.
- code_valid with code_invalid=1 in ENTRY consumes a digit slot.
- Pulses are single-cycle and mutually exclusive.
- unlocked and locked_out are never both 1.

Test Plan:
- Reset, then strobe 7,19,3,28 on consecutive cycles -> after the 4th strobe: unlocked=1, pass_pulse=1 for one cycle; unlocked stays high exactly 500 cycles, then ready=1.
- Enter 7,19,3,27 three times (defaults) -> fail_pulse after each attempt, fail_count 1,2,3; after the 3rd attempt locked_out=1 for exactly 1000 cycles with strobes ignored; then fail_count=0, ready=1.
- Enter 7,19, then idle 200 cycles -> timeout_pulse, digit_count=0, fail_count unchanged; then 7,19,3,28 -> unlock.
- Enter 7,19,3 with code_invalid=1 on the 3rd digit (code=3), then 28 -> fail_pulse, no unlock.
- Unlock, then assert clear at cycle 10 of the window -> unlocked=0 next cycle. Also: clear together with code_valid during entry -> digit dropped, digit_count=0.
- Apply rst for 1 cycle mid-lockout and again after 2 digits -> locked_out=0, fail_count=0, digit_count=0; a fresh correct sequence unlocks.
